// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: mm:ss stopwatch with tick divider, run/pause/lap/clear FSM and sticky overflow
module stopwatch_ctrl #(
    parameter int DIV     = 50_000_000,
    parameter int SEC_MAX = 59,
    parameter int MIN_MAX = 59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start_stop,
    input  logic       i_lap,
    input  logic       i_clear,
    output logic [5:0] o_sec,
    output logic [5:0] o_min,
    output logic [1:0] o_state,
    output logic       o_tick,
    output logic       o_overflow
);
    localparam int DW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_TC = DW'(DIV - 1);
    localparam logic [5:0] S_MAX = 6'(SEC_MAX);
    localparam logic [5:0] M_MAX = 6'(MIN_MAX);
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, LAP = 2'b11} state_t;
    state_t state;
    logic [DW-1:0] div;
    logic [5:0] sec, min, lap_sec, lap_min, sec_nx, min_nx;
    logic run, tc, wrap, clr, ss, lp;
    // Decode run state, divider terminal count, accepted pulses and next count value
    always_comb begin
        run = state == RUN || state == LAP;
        tc = run && div == DIV_TC;
        wrap = sec == S_MAX && min == M_MAX;
        clr = i_clear && (state == IDLE || state == PAUSE);
        ss = i_start_stop && !clr;
        lp = i_lap && !clr && !i_start_stop;
        sec_nx = !tc ? sec : sec == S_MAX ? 6'd0 : sec + 6'd1;
        min_nx = (!tc || sec != S_MAX) ? min : min == M_MAX ? 6'd0 : min + 6'd1;
    end
    // Divider, count, overflow and FSM; a tick on the edge leaving RUN still counts
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            div <= '0;
            sec <= '0;
            min <= '0;
            lap_sec <= '0;
            lap_min <= '0;
            o_tick <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            o_tick <= tc;
            if (clr) begin
                div <= '0;
                sec <= '0;
                min <= '0;
                o_overflow <= 1'b0;
            end else begin
                div <= !run ? div : tc ? '0 : div + DW'(1);
                sec <= sec_nx;
                min <= min_nx;
                if (tc && wrap) o_overflow <= 1'b1;
            end
            case (state)
                IDLE: if (ss) begin
                    state <= RUN;
                    div <= '0;
                end
                RUN: if (ss) state <= PAUSE;
                else if (lp) begin
                    state <= LAP;
                    lap_sec <= sec_nx;
                    lap_min <= min_nx;
                end
                LAP: if (ss) state <= PAUSE;
                else if (lp) state <= RUN;
                PAUSE: if (ss) state <= RUN;
                else if (clr) state <= IDLE;
            endcase
        end
    end
    // Display shows the frozen lap value only while in LAP
    always_comb begin
        o_state = state;
        o_sec = state == LAP ? lap_sec : sec;
        o_min = state == LAP ? lap_min : min;
    end
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: table-driven directed bench for stopwatch_ctrl with DIV=4
module tb_stopwatch_ctrl;
    logic clk = 1'b0, rst = 1'b1, i_start_stop = 1'b0, i_lap = 1'b0, i_clear = 1'b0;
    logic [5:0] o_sec, o_min;
    logic [1:0] o_state;
    logic o_tick, o_overflow;
    int n_vec = 0, n_bad = 0;
    typedef struct {
        logic ss, lp, cl;
        logic [1:0] st;
        int s, m;
        logic t, o;
    } vec_t;
    vec_t tbl[$];

    stopwatch_ctrl #(.DIV(4), .SEC_MAX(59), .MIN_MAX(59)) dut (
        .clk(clk), .rst(rst), .i_start_stop(i_start_stop), .i_lap(i_lap), .i_clear(i_clear),
        .o_sec(o_sec), .o_min(o_min), .o_state(o_state), .o_tick(o_tick), .o_overflow(o_overflow)
    );

    always #5 clk = ~clk;

    task automatic add(input logic ss, lp, cl, input logic [1:0] st, input int s, m, input logic t, o);
        vec_t v;
        v.ss = ss; v.lp = lp; v.cl = cl; v.st = st; v.s = s; v.m = m; v.t = t; v.o = o;
        tbl.push_back(v);
    endtask

    task automatic step(input logic ss, lp, cl);
        i_start_stop = ss; i_lap = lp; i_clear = cl;
        @(posedge clk);
        #1;
        i_start_stop = 1'b0; i_lap = 1'b0; i_clear = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [1:0] st, input int s, m, input logic t, o);
        n_vec++;
        if (o_state !== st || o_sec !== 6'(s) || o_min !== 6'(m) || o_tick !== t || o_overflow !== o) begin
            n_bad++;
            $display("FAIL %s: got state=%0d %0d:%0d tick=%0b ovf=%0b, want state=%0d %0d:%0d tick=%0b ovf=%0b",
                     nm, o_state, o_min, o_sec, o_tick, o_overflow, st, m, s, t, o);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        add(1,0,0, 1,0,0,0,0);
        repeat (3) add(0,0,0, 1,0,0,0,0);
        add(0,0,0, 1,1,0,1,0);
        repeat (3) add(0,0,0, 1,1,0,0,0);
        add(0,0,0, 1,2,0,1,0);
        add(0,0,0, 1,2,0,0,0);
        add(1,0,0, 2,2,0,0,0);
        repeat (2) add(0,0,0, 2,2,0,0,0);
        add(0,1,0, 2,2,0,0,0);
        add(1,0,0, 1,2,0,0,0);
        add(0,0,0, 1,2,0,0,0);
        add(0,0,0, 1,3,0,1,0);
        repeat (3) add(0,0,0, 1,3,0,0,0);
        add(0,0,0, 1,4,0,1,0);
        repeat (3) add(0,0,0, 1,4,0,0,0);
        add(0,0,0, 1,5,0,1,0);
        add(0,1,0, 3,5,0,0,0);
        repeat (2) add(0,0,0, 3,5,0,0,0);
        add(0,0,0, 3,5,0,1,0);
        repeat (3) add(0,0,0, 3,5,0,0,0);
        add(0,0,0, 3,5,0,1,0);
        repeat (3) add(0,0,0, 3,5,0,0,0);
        add(0,0,0, 3,5,0,1,0);
        add(0,1,0, 1,8,0,0,0);
        add(0,0,1, 1,8,0,0,0);
        add(0,1,1, 3,8,0,0,0);
        add(1,0,0, 2,9,0,1,0);
        add(0,0,0, 2,9,0,0,0);
        add(1,0,1, 0,0,0,0,0);
        add(1,0,0, 1,0,0,0,0);
        repeat (3) add(0,0,0, 1,0,0,0,0);
        add(0,0,0, 1,1,0,1,0);
        repeat (3) add(0,0,0, 1,1,0,0,0);
        add(1,0,0, 2,2,0,1,0);
        add(1,0,0, 1,2,0,0,0);
        repeat (3) add(0,0,0, 1,2,0,0,0);
        add(0,0,0, 1,3,0,1,0);

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset", 0, 0, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].ss, tbl[i].lp, tbl[i].cl);
            chk($sformatf("vec%0d", i + 1), tbl[i].st, tbl[i].s, tbl[i].m, tbl[i].t, tbl[i].o);
        end

        repeat (16) step(0, 0, 0);
        chk("run_to_7", 1, 7, 0, 1, 0);
        repeat (3) step(0, 0, 0);
        rst = 1'b1;
        step(1, 1, 0);
        rst = 1'b0;
        chk("rst_mid_run", 0, 0, 0, 0, 0);
        step(0, 0, 0);
        chk("after_rst_idle", 0, 0, 0, 0, 0);

        step(1, 0, 0);
        chk("ovf_start", 1, 0, 0, 0, 0);
        repeat (4 * 3599) step(0, 0, 0);
        chk("reach_59_59", 1, 59, 59, 1, 0);
        repeat (4) step(0, 0, 0);
        chk("wrap_00_00", 1, 0, 0, 1, 1);
        repeat (4) step(0, 0, 0);
        chk("ovf_sticky", 1, 1, 0, 1, 1);
        step(1, 0, 0);
        chk("ovf_pause", 2, 1, 0, 0, 1);
        step(0, 0, 1);
        chk("pause_clear", 0, 0, 0, 0, 0);
        step(0, 0, 1);
        chk("idle_clear", 0, 0, 0, 0, 0);
        step(0, 1, 0);
        chk("idle_lap_ignored", 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
